// File: rtl/aes_frame_loader.sv
// Byte-stream loader for the AES path: collects a header, a 128-bit block and an
// optional 192-bit key, then holds them on the outputs until the consumer acks.
module aes_frame_loader #(
  parameter int NK      = 6,
  parameter int NB      = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [32*NB-1:0]  msg_out,
  output logic [32*NK-1:0]  key_out,
  output logic              valid_curr_data,
  input  logic              blk_ack,
  output logic              key_loaded,
  output logic              frame_err
);

  localparam int MSG_BYTES = 4 * NB;
  localparam int KEY_BYTES = 4 * NK;
  localparam int MW = 32 * NB;
  localparam int KW = 32 * NK;
  localparam int MAXB = (KEY_BYTES > MSG_BYTES) ? KEY_BYTES : MSG_BYTES;
  localparam int CW = $clog2(MAXB);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] HDR_KEY = 8'hA5;
  localparam logic [7:0] HDR_MSG = 8'h5A;

  typedef enum logic [1:0] {IDLE, MSG, KEY, PRESENT} state_t;

  state_t          state;
  logic            need_key;
  logic [CW-1:0]   bcnt;
  logic [TW-1:0]   tcnt;
  logic [MW-1:0]   msg_stg;
  logic [KW-1:0]   key_stg;
  logic            accept;
  logic [MW-1:0]   msg_nxt;
  logic [KW-1:0]   key_nxt;

  // Held low for the whole reset cycle, not just after the first reset edge.
  assign in_ready = rst && (state != PRESENT);
  assign accept   = in_valid && in_ready;
  assign msg_nxt  = {msg_stg[MW-9:0], in_data};
  assign key_nxt  = {key_stg[KW-9:0], in_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      need_key        <= 1'b0;
      bcnt            <= '0;
      tcnt            <= '0;
      msg_stg         <= '0;
      key_stg         <= '0;
      msg_out         <= '0;
      key_out         <= '0;
      valid_curr_data <= 1'b0;
      key_loaded      <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bcnt <= '0;
            tcnt <= '0;
            if (in_data == HDR_KEY) begin
              state    <= MSG;
              need_key <= 1'b1;
            end else if (in_data == HDR_MSG) begin
              if (key_loaded) begin
                state    <= MSG;
                need_key <= 1'b0;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
        end

        MSG, KEY: begin
          if (accept) begin
            tcnt <= '0;
            if (state == MSG) msg_stg <= msg_nxt;
            else              key_stg <= key_nxt;
            if (state == MSG && bcnt == CW'(MSG_BYTES - 1)) begin
              bcnt <= '0;
              if (need_key) begin
                state <= KEY;
              end else begin
                state           <= PRESENT;
                valid_curr_data <= 1'b1;
                msg_out         <= msg_nxt;
              end
            end else if (state == KEY && bcnt == CW'(KEY_BYTES - 1)) begin
              bcnt            <= '0;
              state           <= PRESENT;
              valid_curr_data <= 1'b1;
              msg_out         <= msg_stg;
              key_out         <= key_nxt;
              key_loaded      <= 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // Stalled frame: drop the partial data, leave presented outputs alone.
            frame_err <= 1'b1;
            state     <= IDLE;
            bcnt      <= '0;
            tcnt      <= '0;
            msg_stg   <= '0;
            key_stg   <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        PRESENT: begin
          if (blk_ack) begin
            state           <= IDLE;
            valid_curr_data <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_frame_loader.sv
// Directed bench for aes_frame_loader: full/message-only frames, hold/ack,
// junk header, timeout, reset mid-key and throttled input.
module tb_aes_frame_loader;
  localparam int TIMEOUT = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [127:0] msg_out;
  logic [191:0] key_out;
  logic         valid_curr_data;
  logic         blk_ack;
  logic         key_loaded;
  logic         frame_err;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;

  localparam logic [127:0] MSG1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] KEY1 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] MSG3 = 128'h808182838485868788898a8b8c8d8e8f;
  localparam logic [191:0] KEY3 = 192'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3d4d5d6d7;
  localparam logic [127:0] MSG4 = 128'h12121212121212121212121212121212;

  aes_frame_loader #(.NK(6), .NB(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .msg_out(msg_out), .key_out(key_out),
    .valid_curr_data(valid_curr_data), .blk_ack(blk_ack),
    .key_loaded(key_loaded), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt++;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [7:0] b);
    in_valid = 1'b1; in_data = b; tick();
  endtask

  task automatic ack();
    in_valid = 1'b0; blk_ack = 1'b1; tick(); blk_ack = 1'b0;
  endtask

  initial begin
    int e0;
    int first_err;
    int nerr;
    logic hold_ok;
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; blk_ack = 1'b0;
    tick(); tick();
    chk("rst_msg", msg_out, 0);
    chk("rst_key", key_out, 0);
    chk("rst_valid", valid_curr_data, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_keyld", key_loaded, 0);
    chk("rst_err", frame_err, 0);
    rst = 1'b1; #1;
    chk("idle_ready", in_ready, 1);

    // full frame, in_valid held high
    put(8'hA5);
    for (int i = 0; i < 16; i++) put(8'(i * 17));
    for (int i = 0; i < 23; i++) put(8'(i));
    chk("pre_last_valid", valid_curr_data, 0);
    put(8'd23);
    chk("f1_valid", valid_curr_data, 1);
    chk("f1_msg", msg_out, MSG1);
    chk("f1_key", key_out, KEY1);
    chk("f1_keyld", key_loaded, 1);

    // hold while bytes are offered
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      put(8'h5A);
      if (!(valid_curr_data === 1'b1 && in_ready === 1'b0)) hold_ok = 1'b0;
    end
    chk("hold", hold_ok, 1);
    chk("hold_msg", msg_out, MSG1);
    ack();
    chk("ack_valid", valid_curr_data, 0);
    chk("ack_ready", in_ready, 1);

    // message only
    put(8'h5A);
    for (int i = 0; i < 16; i++) put(8'hff);
    in_valid = 1'b0;
    chk("mo_valid", valid_curr_data, 1);
    chk("mo_msg", msg_out, {128{1'b1}});
    chk("mo_key", key_out, KEY1);
    ack();

    // junk header dropped, then a message-only frame
    e0 = err_cnt;
    put(8'h33);
    in_valid = 1'b0; tick();
    chk("junk_err", err_cnt - e0, 0);
    chk("junk_valid", valid_curr_data, 0);
    put(8'h5A);
    for (int i = 0; i < 16; i++) put(8'h12);
    in_valid = 1'b0;
    chk("junk_next_msg", msg_out, MSG4);
    chk("junk_next_valid", valid_curr_data, 1);
    ack();

    // timeout after header + 5 bytes
    put(8'hA5);
    for (int i = 0; i < 5; i++) put(8'h77);
    in_valid = 1'b0;
    first_err = -1; nerr = 0;
    for (int i = 1; i <= TIMEOUT + 10; i++) begin
      tick();
      if (frame_err) begin
        nerr++;
        if (first_err < 0) first_err = i;
      end
    end
    chk("to_pulses", nerr, 1);
    chk("to_cycle", first_err, TIMEOUT);
    chk("to_msg_kept", msg_out, MSG4);
    chk("to_valid", valid_curr_data, 0);
    put(8'hA5);
    for (int i = 0; i < 16; i++) put(8'(8'h80 + i));
    for (int i = 0; i < 24; i++) put(8'(8'hc0 + i));
    in_valid = 1'b0;
    chk("after_to_msg", msg_out, MSG3);
    chk("after_to_key", key_out, KEY3);
    chk("after_to_valid", valid_curr_data, 1);
    ack();

    // reset mid-key
    put(8'hA5);
    for (int i = 0; i < 16; i++) put(8'h44);
    for (int i = 0; i < 10; i++) put(8'h55);
    in_valid = 1'b0; rst = 1'b0;
    e0 = err_cnt;
    tick();
    chk("mk_msg", msg_out, 0);
    chk("mk_key", key_out, 0);
    chk("mk_keyld", key_loaded, 0);
    chk("mk_valid", valid_curr_data, 0);
    chk("mk_ready", in_ready, 0);
    rst = 1'b1; #1;
    chk("mk_no_err", err_cnt - e0, 0);

    // 5A with no key loaded
    put(8'h5A);
    in_valid = 1'b0;
    chk("nokey_err", frame_err, 1);
    tick();
    chk("nokey_err_1cyc", frame_err, 0);
    chk("nokey_valid", valid_curr_data, 0);

    // throttled full frame
    e0 = err_cnt;
    put(8'hA5); in_valid = 1'b0; tick();
    for (int i = 0; i < 16; i++) begin put(8'(i * 17)); in_valid = 1'b0; tick(); end
    for (int i = 0; i < 23; i++) begin put(8'(i)); in_valid = 1'b0; tick(); end
    put(8'd23);
    in_valid = 1'b0;
    chk("thr_valid", valid_curr_data, 1);
    chk("thr_msg", msg_out, MSG1);
    chk("thr_key", key_out, KEY1);
    chk("thr_keyld", key_loaded, 1);
    chk("thr_no_err", err_cnt - e0, 0);
    ack();
    chk("thr_ack", valid_curr_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_frame_loader.md
Name: aes_frame_loader

Overview:
- Upstream feeder for the AES Master/encryption path.
- Assembles a byte stream into one 128-bit plaintext block and an optional 192-bit key, then presents them on from_Real_msg/from_Real_key-style outputs with a valid_curr_data qualifier.
- Holds the presented block until the consumer acknowledges it.
- Replaces the hard-coded message/key registers at the top level, so arbitrary vectors can be driven from a UART/byte source.

Parameters:
- NK, 6, key length in 32-bit words (KEY_BYTES = 4*NK = 24).
- NB, 4, block length in 32-bit words (MSG_BYTES = 4*NB = 16).
- TIMEOUT, 1000, maximum idle cycles allowed between accepted bytes inside a frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- msg_out  output  32*NB  plaintext block to Master from_Real_msg.
- key_out  output  32*NK  key to Master from_Real_key.
- valid_curr_data  output  1  msg_out/key_out valid; drives Master valid_curr_data.
- blk_ack  input  1  consumer has taken the block (tie to Master cs_enc_dec completion).
- key_loaded  output  1  a full key has been received since reset.
- frame_err  output  1  one-cycle pulse on a frame error.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE.
  - msg_out=0, key_out=0, valid_curr_data=0, key_loaded=0, frame_err=0, in_ready=0 during reset.
  - Staging registers, byte counter and timeout counter cleared.
- Byte accept: a byte is accepted on a cycle where in_valid=1 and in_ready=1.
- in_ready=1 in IDLE, MSG and KEY; in_ready=0 in PRESENT and during reset.
- Frame format: header byte, then MSG_BYTES message bytes, then KEY_BYTES key bytes if the header requires a key.
  - 0xA5 = message + key.
  - 0x5A = message only; reuse the current key_out.
- Byte order: the first data byte lands in the MSB.
  - Message bytes 00,11,..,ff give 128'h00112233445566778899aabbccddeeff.
  - Key bytes fill key_out the same way, MSB first.
- Bytes are shifted into staging registers; msg_out/key_out change only on entry to PRESENT.
- States:
  - IDLE: on an accepted byte:
    - 0xA5 -> MSG, with need_key=1.
    - 0x5A and key_loaded=1 -> MSG, with need_key=0.
    - 0x5A and key_loaded=0 -> frame_err pulse, stay IDLE.
    - Any other byte -> silently dropped, stay IDLE.
  - MSG: count accepted bytes 0..MSG_BYTES-1. On acceptance of byte MSG_BYTES-1, go to KEY if need_key, else PRESENT.
  - KEY: count accepted bytes 0..KEY_BYTES-1. On the last byte, go to PRESENT.
  - PRESENT:
    - On the entry edge, copy staging to msg_out (and to key_out if need_key).
    - If need_key, set key_loaded=1.
    - valid_curr_data=1 for as long as the state is PRESENT.
    - blk_ack=1 sampled -> IDLE next edge; valid_curr_data=0 and in_ready=1 from that cycle.
- Latency:
  - The last byte is accepted on edge N; valid_curr_data is high in the cycle after edge N.
  - Minimum PRESENT dwell is 1 cycle, when blk_ack is already high.
- blk_ack while not in PRESENT is ignored.
- msg_out/key_out hold their last presented values after PRESENT; they change only on the next PRESENT entry.
- Timeout:
  - In MSG/KEY, a counter increments on every cycle with no accepted byte and clears on an accepted byte.
  - When the count reaches TIMEOUT: frame_err pulses, state goes to IDLE, staging is discarded, outputs are unchanged.
- Reset mid-frame or in PRESENT: immediate return to the reset values above; no partial data is presented.
- frame_err is high for exactly one cycle per error. It is never asserted by reset.

Test Plan:
- Full frame: A5, 00 11 .. ff, 00 01 .. 17 with in_valid held high -> valid_curr_data rises 1 cycle after the final byte. msg_out=128'h00112233445566778899aabbccddeeff, key_out=192'h000102030405060708090a0b0c0d0e0f1011121314151617, key_loaded=1.
- Hold/ack: no blk_ack for 50 cycles -> valid_curr_data stays 1, in_ready=0 and bytes are not accepted. Pulse blk_ack -> valid_curr_data=0 and in_ready=1 the next cycle.
- Message-only: after the first scenario, send 5A, then 16 bytes of ff -> msg_out=all ff, key_out unchanged. Sending 5A directly after reset -> frame_err pulse, state stays IDLE.
- Junk and timeout: send 33 in IDLE -> dropped, no error. Send A5 plus 5 bytes, then idle TIMEOUT cycles -> single frame_err pulse, back to IDLE. A following good frame is received correctly.
- Reset mid-KEY: drop rst to 0 after the 10th key byte -> all outputs 0 and key_loaded=0. A fresh full frame after reset works.
- Throttled input: in_valid toggled every other cycle through a full frame -> same result as the first scenario, with no timeout.
